mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Multi-cycle control unit for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and write-back states. From the opcode and funct fields held in the instruction register, it drives all datapath enables and selects, including the 2-bit ExtOp consumed by the immediate extender. It sits between the instruction register and the datapath. Only the state is registered; all outputs are decoded from state, op, funct and zero.

## Interface
- STATE_W, 4, width of state register / debug state output
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- op  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (beq compare)
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  register file write enable
- MemWr  out  1  data memory write enable
- ExtOp  out  2  ZE=00, SE=01, HC=10, HZE=11
- ALUOp  out  3  ADD=0, SUB=1, OR=2, SLT=3, SLL=4, SRL=5
- ALUSrcA  out  1  0 rs data, 1 rt data
- ALUSrcB  out  1  0 rt data, 1 Imm32
- RegDst  out  2  0 rt, 1 rd, 2 $31
- MemToReg  out  2  0 ALU result, 1 memory data, 2 PC
- NPCOp  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs (jr)
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op/funct
- state  out  STATE_W  current state, for debug

## Operation
- States:
  - FETCH=0, DECODE=1, EXE=2, MEMADR=3, MEMRD=4, MEMWR=5
  - LWB=6, RWB=7, BRANCH=8, JUMP=9
- Supported instructions:
  - R-type (op 000000) by funct: addu 100001, subu 100011, slt 101010, sll 000000, srl 000010, jr 001000
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011
- FETCH:
  - IRWr=1, PCWr=1, NPCOp=0
  - next state DECODE
- DECODE: no write enables asserted. Next state:
  - lw/sw → MEMADR
  - beq → BRANCH
  - j/jal/jr → JUMP
  - other supported instructions → EXE
  - unsupported → illegal=1, next FETCH
- EXE, then RWB:
  - addu, subu, slt: ALUOp ADD/SUB/SLT, ALUSrcA=0, ALUSrcB=0, RegDst=1
  - sll/srl: ALUSrcA=1, ALUSrcB=1, ExtOp=HZE (shamt), RegDst=1
  - addiu: ExtOp=SE, ALUOp=ADD, ALUSrcB=1, RegDst=0
  - ori: ExtOp=ZE, ALUOp=OR, ALUSrcB=1, RegDst=0
  - lui: ExtOp=HC, ALUOp=OR, ALUSrcB=1, RegDst=0 (rs=$0)
- RWB:
  - RegWr=1, MemToReg=0
  - selects held from EXE
  - next FETCH
- MEMADR:
  - ExtOp=SE, ALUOp=ADD, ALUSrcB=1
  - next MEMRD (lw) or MEMWR (sw)
- MEMRD → LWB; MEMWR: MemWr=1 → FETCH.
- LWB:
  - RegWr=1, MemToReg=1, RegDst=0
  - next FETCH
- BRANCH:
  - ALUOp=SUB, ALUSrcB=0, ExtOp=SE, NPCOp=1
  - PCWr=zero
  - next FETCH
- JUMP:
  - j: NPCOp=2, PCWr=1
  - jal: additionally RegWr=1, RegDst=2, MemToReg=2
  - jr: NPCOp=3, PCWr=1
  - next FETCH
- Unlisted outputs default to 0 in every state. State encodings 10–15 are unreachable; if entered, next state is FETCH and all enables are 0.

## Timing
- The state register updates on rising clk. rst_n low immediately forces state=FETCH.
- While rst_n is low, PCWr/IRWr/RegWr/MemWr/illegal are forced to 0; the other outputs show FETCH decode.
- The first rising edge after rst_n deasserts performs a fetch.
- Cycles per instruction:
  - R-type/I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq, j, jal, jr: 3
  - unsupported: 2
- Reset asserted mid-instruction aborts it; no write enable is asserted in the reset cycle or after it.
- zero is sampled combinationally in BRANCH only.

## Test plan
- Reset, then op=001101 (ori):
  - states 0→1→2→7→0
  - ExtOp=00 and ALUSrcB=1 in EXE
  - RegWr=1 only in RWB
- lw (100011):
  - 5-cycle sequence 0,1,3,4,6
  - ExtOp=01 in MEMADR
  - RegWr=1, MemToReg=1 in LWB
  - MemWr never asserted
- beq with zero=1, then zero=0:
  - PCWr=1 with NPCOp=1 in BRANCH for the first, PCWr=0 for the second
  - both return to FETCH after 3 cycles
- R-type funct=000000 (sll):
  - ExtOp=11, ALUSrcA=1, ALUOp=4 in EXE
  - jal: RegWr=1, RegDst=2, MemToReg=2, PCWr=1 in JUMP
- op=111111:
  - illegal=1 for exactly one cycle in DECODE
  - no writes
  - back to FETCH
- rst_n pulsed low during MEMWR of sw:
  - MemWr drops to 0 asynchronously
  - state=0
  - the next cycle after release fetches

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the MIPS datapath (slave).
// The master receives IR fields and the ALU zero flag and drives every enable/select.
interface mc_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               PCWr;
  logic               IRWr;
  logic               RegWr;
  logic               MemWr;
  logic [1:0]         ExtOp;
  logic [2:0]         ALUOp;
  logic               ALUSrcA;
  logic               ALUSrcB;
  logic [1:0]         RegDst;
  logic [1:0]         MemToReg;
  logic [1:0]         NPCOp;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrcA, ALUSrcB,
    output RegDst, MemToReg, NPCOp, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrcA, ALUSrcB,
    input  RegDst, MemToReg, NPCOp, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back.
// Only the state is registered; every output is decoded from state, op, funct and zero.
module mc_ctrl_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExe    = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWr  = 4'd5,
    StLwb    = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [1:0] ExtZe  = 2'b00;
  localparam logic [1:0] ExtSe  = 2'b01;
  localparam logic [1:0] ExtHc  = 2'b10;
  localparam logic [1:0] ExtHze = 2'b11;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluOr  = 3'd2;
  localparam logic [2:0] AluSlt = 3'd3;
  localparam logic [2:0] AluSll = 3'd4;
  localparam logic [2:0] AluSrl = 3'd5;

  state_e state_q, state_d;

  logic is_rtype;
  logic is_addu, is_subu, is_slt, is_sll, is_srl, is_jr;
  logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_alu;

  assign is_rtype = (bus.op == 6'b000000);
  assign is_addu  = is_rtype && (bus.funct == 6'b100001);
  assign is_subu  = is_rtype && (bus.funct == 6'b100011);
  assign is_slt   = is_rtype && (bus.funct == 6'b101010);
  assign is_sll   = is_rtype && (bus.funct == 6'b000000);
  assign is_srl   = is_rtype && (bus.funct == 6'b000010);
  assign is_jr    = is_rtype && (bus.funct == 6'b001000);
  assign is_addiu = (bus.op == 6'b001001);
  assign is_ori   = (bus.op == 6'b001101);
  assign is_lui   = (bus.op == 6'b001111);
  assign is_lw    = (bus.op == 6'b100011);
  assign is_sw    = (bus.op == 6'b101011);
  assign is_beq   = (bus.op == 6'b000100);
  assign is_j     = (bus.op == 6'b000010);
  assign is_jal   = (bus.op == 6'b000011);
  assign is_alu   = is_addu | is_subu | is_slt | is_sll | is_srl | is_addiu | is_ori | is_lui;

  logic       pc_wr, ir_wr, reg_wr, mem_wr, illegal_c;
  logic [1:0] ext_op, reg_dst, mem_to_reg, npc_op;
  logic [2:0] alu_op;
  logic       alu_src_a, alu_src_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    illegal_c  = 1'b0;
    ext_op     = ExtZe;
    alu_op     = AluAdd;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    npc_op     = 2'd0;

    case (state_q)
      StFetch: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_lw || is_sw)              state_d = StMemAdr;
        else if (is_beq)                 state_d = StBranch;
        else if (is_j || is_jal || is_jr) state_d = StJump;
        else if (is_alu)                 state_d = StExe;
        else begin
          illegal_c = 1'b1;
          state_d   = StFetch;
        end
      end
      // RWB keeps the EXE selects so the ALU result stays valid while it is written back.
      StExe, StRwb: begin
        if (is_addu) begin
          alu_op  = AluAdd;
          reg_dst = 2'd1;
        end else if (is_subu) begin
          alu_op  = AluSub;
          reg_dst = 2'd1;
        end else if (is_slt) begin
          alu_op  = AluSlt;
          reg_dst = 2'd1;
        end else if (is_sll || is_srl) begin
          alu_op    = is_sll ? AluSll : AluSrl;
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
          ext_op    = ExtHze;
          reg_dst   = 2'd1;
        end else if (is_addiu) begin
          ext_op    = ExtSe;
          alu_op    = AluAdd;
          alu_src_b = 1'b1;
        end else if (is_ori || is_lui) begin
          ext_op    = is_lui ? ExtHc : ExtZe;
          alu_op    = AluOr;
          alu_src_b = 1'b1;
        end
        if (state_q == StRwb) begin
          reg_wr  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StRwb;
        end
      end
      StMemAdr: begin
        ext_op    = ExtSe;
        alu_op    = AluAdd;
        alu_src_b = 1'b1;
        state_d   = is_lw ? StMemRd : StMemWr;
      end
      StMemRd: state_d = StLwb;
      StMemWr: mem_wr = 1'b1;
      StLwb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'd1;
      end
      StBranch: begin
        alu_op = AluSub;
        ext_op = ExtSe;
        npc_op = 2'd1;
        pc_wr  = bus.zero;
      end
      StJump: begin
        pc_wr  = 1'b1;
        npc_op = is_jr ? 2'd3 : 2'd2;
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Write enables are gated by rst_n so an asserted reset silences them immediately.
  assign bus.PCWr     = pc_wr & rst_n;
  assign bus.IRWr     = ir_wr & rst_n;
  assign bus.RegWr    = reg_wr & rst_n;
  assign bus.MemWr    = mem_wr & rst_n;
  assign bus.illegal  = illegal_c & rst_n;
  assign bus.ExtOp    = ext_op;
  assign bus.ALUOp    = alu_op;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.RegDst   = reg_dst;
  assign bus.MemToReg = mem_to_reg;
  assign bus.NPCOp    = npc_op;
  assign bus.state    = STATE_W'(state_q);

endmodule
